// File: rtl/laser_feeder_pkg.sv
// Shared definitions for the laser feeder slice: the default object count,
// the counter type, the FSM state encoding, and the packed coordinate and
// result types.
`timescale 1ns/1ps
package laser_pkg;

    localparam int unsigned OBJ_NUM_DEF = 40;
    localparam int unsigned CNT_W       = 6;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_KICK,
        ST_STREAM,
        ST_WAIT,
        ST_RESULT
    } state_t;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } coord_t;

    typedef struct packed {
        coord_t c1;
        coord_t c2;
    } result_t;

    // Index of the last object in a frame of n objects.
    function automatic cnt_t last_idx(input int unsigned n);
        return cnt_t'(n - 1);
    endfunction

endpackage

// File: rtl/laser_feeder_if.sv
// Host-side streams of the laser feeder.
//   in_*  : object stream, host -> feeder (valid/ready, 4-bit x/y)
//   out_* : result stream, feeder -> host (valid/ready, C1/C2 coordinates)
// Modports: master = host, slave = feeder.
`timescale 1ns/1ps
interface laser_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_c1x;
    logic [3:0] out_c1y;
    logic [3:0] out_c2x;
    logic [3:0] out_c2y;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_c1x, out_c1y, out_c2x, out_c2y
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_c1x, out_c1y, out_c2x, out_c2y
    );
endinterface

// File: rtl/laser_feeder_obj_buf.sv
// Object register file: DEPTH x 8-bit coordinates, one synchronous write
// port and one asynchronous read port. Contents are not reset.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
`timescale 1ns/1ps
module laser_obj_buf
    import laser_pkg::*;
#(
    parameter int unsigned DEPTH = OBJ_NUM_DEF
) (
    input  logic   clk,
    input  logic   we_i,
    input  cnt_t   waddr_i,
    input  coord_t wdata_i,
    input  cnt_t   raddr_i,
    output coord_t rdata_o
);

    coord_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/laser_feeder.sv
// Laser feeder: collects OBJ_NUM objects from the host, resets the laser
// core for one cycle, streams the objects one per cycle in arrival order,
// waits for the core's L_DONE, and hands the captured C1/C2 result to the
// host over a valid/ready stream.
// Ports: clk, rst_n (async active-low), host (laser_feeder_if.slave),
//        l_rst_o/l_x_o/l_y_o (core drive), l_c*_i/l_done_i (core result),
//        err_o (watchdog expiry, sticky until reset).
// Optional feature: define LASER_FEEDER_TIMEOUT_EN to enable the WAIT
// watchdog (TIMEOUT_CYC cycles); otherwise WAIT is unbounded and err_o = 0.
`timescale 1ns/1ps
module laser_feeder
    import laser_pkg::*;
#(
    parameter int unsigned OBJ_NUM     = OBJ_NUM_DEF,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    laser_feeder_if.slave host,
    output logic       l_rst_o,
    output logic [3:0] l_x_o,
    output logic [3:0] l_y_o,
    input  logic [3:0] l_c1x_i,
    input  logic [3:0] l_c1y_i,
    input  logic [3:0] l_c2x_i,
    input  logic [3:0] l_c2y_i,
    input  logic       l_done_i,
    output logic       err_o
);

    localparam cnt_t LAST = last_idx(OBJ_NUM);

    if (OBJ_NUM < 2 || OBJ_NUM > 64 || TIMEOUT_CYC == 0) begin : g_cfg_check
        $error("laser_feeder: OBJ_NUM must be 2..64 and TIMEOUT_CYC nonzero");
    end

    state_t  state_q;
    cnt_t    wr_cnt_q;
    cnt_t    rd_cnt_q;
    logic    l_rst_q;
    logic    out_valid_q;
    result_t res_q;
    logic    wr_en;
    coord_t  wr_obj;
    coord_t  rd_obj;

`ifdef LASER_FEEDER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    typedef logic [WD_W-1:0] wd_t;
    localparam wd_t WD_LAST = wd_t'(TIMEOUT_CYC - 1);
    wd_t  wd_q;
    logic err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Ready is a pure state decode, gated by reset so it drops the moment
    // rst_n goes low rather than at the next edge.
    assign host.in_ready = rst_n && (state_q == ST_LOAD);
    assign wr_en         = host.in_ready && host.in_valid;
    assign wr_obj.x      = host.in_x;
    assign wr_obj.y      = host.in_y;

    laser_obj_buf #(.DEPTH(OBJ_NUM)) u_obj_buf (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_cnt_q),
        .wdata_i (wr_obj),
        .raddr_i (rd_cnt_q),
        .rdata_o (rd_obj)
    );

    // Objects reach the core straight from the buffer read port so that
    // the first edge after L_RST falls already sees object 0.
    always_comb begin
        l_x_o = '0;
        l_y_o = '0;
        if (state_q == ST_STREAM) begin
            l_x_o = rd_obj.x;
            l_y_o = rd_obj.y;
        end
    end

    assign l_rst_o        = l_rst_q;
    assign host.out_valid = out_valid_q;
    assign host.out_c1x   = res_q.c1.x;
    assign host.out_c1y   = res_q.c1.y;
    assign host.out_c2x   = res_q.c2.x;
    assign host.out_c2y   = res_q.c2.y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            l_rst_q     <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
`ifdef LASER_FEEDER_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (wr_en) begin
                        if (wr_cnt_q == LAST) begin
                            wr_cnt_q <= '0;
                            state_q  <= ST_KICK;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                ST_KICK: begin
                    l_rst_q  <= 1'b0;
                    rd_cnt_q <= '0;
                    state_q  <= ST_STREAM;
`ifdef LASER_FEEDER_TIMEOUT_EN
                    wd_q     <= '0;
`endif
                end
                ST_STREAM: begin
                    if (rd_cnt_q == LAST) begin
                        rd_cnt_q <= '0;
                        state_q  <= ST_WAIT;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (l_done_i) begin
                        res_q       <= {l_c1y_i, l_c1x_i, l_c2y_i, l_c2x_i};
                        out_valid_q <= 1'b1;
                        l_rst_q     <= 1'b1;
                        state_q     <= ST_RESULT;
                    end
`ifdef LASER_FEEDER_TIMEOUT_EN
                    else if (wd_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        l_rst_q <= 1'b1;
                        state_q <= ST_LOAD;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                ST_RESULT: begin
                    if (host.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_feeder.sv
// Self-checking bench for laser_feeder: a frame-level reference model
// (queue of accepted objects, phase of the frame) is compared with every
// DUT output on every falling clock edge, plus literal expectations for
// the ordered-frame, held-result and reset-mid-stream scenarios.
`timescale 1ns/1ps
module tb_laser_feeder;
    import laser_pkg::*;

    localparam int N  = OBJ_NUM_DEF;
    localparam int TO = 16;

    localparam int P_LOAD   = 0;
    localparam int P_KICK   = 1;
    localparam int P_STREAM = 2;
    localparam int P_WAIT   = 3;
    localparam int P_RESULT = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       l_rst;
    logic [3:0] l_x, l_y;
    logic [3:0] c1x = '0, c1y = '0, c2x = '0, c2y = '0;
    logic       l_done = 1'b0;
    logic       err;

    laser_feeder_if hif ();

    laser_feeder #(.OBJ_NUM(N), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (hif),
        .l_rst_o  (l_rst),
        .l_x_o    (l_x),
        .l_y_o    (l_y),
        .l_c1x_i  (c1x),
        .l_c1y_i  (c1y),
        .l_c2x_i  (c2x),
        .l_c2y_i  (c2y),
        .l_done_i (l_done),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired, required event never seen at %0t", name, $time);
    endtask

    // ---------------- stimulus controls for core and host-out side ----------
    int          or_mode   = 0;      // 0 directed, 1 random, 2 tied high
    logic        dir_rdy   = 1'b0;
    bit          core_rand = 1'b0;
    logic        dir_done  = 1'b0;
    logic [15:0] dir_c     = '0;     // {c1x, c1y, c2x, c2y}

    initial begin
        hif.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (or_mode)
                0:       hif.out_ready = dir_rdy;
                1:       hif.out_ready = 1'($urandom_range(0, 1));
                default: hif.out_ready = 1'b1;
            endcase
            if (core_rand) begin
                l_done = ($urandom_range(0, 5) == 0);
                c1x = 4'($urandom());
                c1y = 4'($urandom());
                c2x = 4'($urandom());
                c2y = 4'($urandom());
            end else begin
                l_done = dir_done;
                c1x = dir_c[15:12];
                c1y = dir_c[11:8];
                c2x = dir_c[7:4];
                c2y = dir_c[3:0];
            end
        end
    end

    // ---------------- reference model ----------------
    int          m_phase = P_LOAD;
    logic [7:0]  m_frame [$];
    int          m_sidx  = 0;
    logic [15:0] m_res   = '0;
    bit          m_err   = 1'b0;
    int          m_wcnt  = 0;

    task automatic model_step();
        case (m_phase)
            P_LOAD: if (hif.in_valid) begin
                m_frame.push_back({hif.in_y, hif.in_x});
                if (m_frame.size() == N) m_phase = P_KICK;
            end
            P_KICK: begin
                m_phase = P_STREAM;
                m_sidx  = 0;
            end
            P_STREAM: begin
                if (m_sidx == N - 1) begin
                    m_phase = P_WAIT;
                    m_wcnt  = 0;
                end else begin
                    m_sidx++;
                end
            end
            P_WAIT: begin
                if (l_done) begin
                    m_res   = {c1x, c1y, c2x, c2y};
                    m_phase = P_RESULT;
                end
`ifdef LASER_FEEDER_TIMEOUT_EN
                else begin
                    m_wcnt++;
                    if (m_wcnt == TO) begin
                        m_err   = 1'b1;
                        m_phase = P_LOAD;
                        m_frame.delete();
                    end
                end
`endif
            end
            default: if (hif.out_ready) begin
                m_phase = P_LOAD;
                m_frame.delete();
            end
        endcase
    endtask

    task automatic model_compare();
        logic [7:0] e;
        e = (m_phase == P_STREAM) ? m_frame[m_sidx] : 8'h00;
        chk("in_ready",  16'(hif.in_ready), 16'(rst_n && m_phase == P_LOAD));
        chk("l_rst",     16'(l_rst), 16'(!(m_phase == P_STREAM || m_phase == P_WAIT)));
        chk("l_x",       16'(l_x), 16'(e[3:0]));
        chk("l_y",       16'(l_y), 16'(e[7:4]));
        chk("out_valid", 16'(hif.out_valid), 16'(m_phase == P_RESULT));
        chk("out_c",     {hif.out_c1x, hif.out_c1y, hif.out_c2x, hif.out_c2y}, m_res);
        chk("err",       16'(err), 16'(m_err));
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = P_LOAD;
                m_frame.delete();
                m_sidx  = 0;
                m_res   = '0;
                m_err   = 1'b0;
            end else begin
                model_step();
            end
            @(negedge clk);
            model_compare();
        end
    end

    // ---------------- host-in driver ----------------
    logic [7:0] fdata [N];

    task automatic fill_random();
        foreach (fdata[i]) fdata[i] = 8'($urandom());
    endtask

    // vmode: 0 constant valid, 1 toggling valid, 2 random valid
    // dmode: 0 x=k%16 y=k/16, 1 fdata[k]
    task automatic send_frame(input int vmode, input int dmode);
        int   k = 0;
        int   budget = 0;
        logic v = 1'b0;
        logic go;
        while (k < N && budget < 1000) begin
            @(negedge clk);
            budget++;
            case (vmode)
                0:       v = 1'b1;
                1:       v = ~v;
                default: v = 1'($urandom_range(0, 1));
            endcase
            hif.in_valid = v;
            if (!v) begin
                hif.in_x = 4'($urandom());
                hif.in_y = 4'($urandom());
            end else if (dmode == 0) begin
                hif.in_x = 4'(k % 16);
                hif.in_y = 4'(k / 16);
            end else begin
                hif.in_x = fdata[k][3:0];
                hif.in_y = fdata[k][7:4];
            end
            go = v && hif.in_ready;
            @(posedge clk);
            if (go) k++;
        end
        if (k < N) fail_bound("send_frame");
    endtask

    // Junk on the input stream while the frame is being processed.
    task automatic wait_load(input int budget);
        int n = 0;
        @(negedge clk);
        while (m_phase != P_LOAD && n < budget) begin
            hif.in_valid = 1'($urandom_range(0, 1));
            hif.in_x     = 4'($urandom());
            hif.in_y     = 4'($urandom());
            @(negedge clk);
            n++;
        end
        hif.in_valid = 1'b0;
        if (m_phase != P_LOAD) fail_bound("wait_load");
    endtask

    task automatic wait_stream_idx(input int idx);
        int n = 0;
        while (!(m_phase == P_STREAM && m_sidx == idx) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(m_phase == P_STREAM && m_sidx == idx)) fail_bound("wait_stream_idx");
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  16'(hif.in_ready), 16'h0);
        chk({tag, "_l_rst"},     16'(l_rst), 16'h1);
        chk({tag, "_l_xy"},      16'({l_y, l_x}), 16'h0);
        chk({tag, "_out_valid"}, 16'(hif.out_valid), 16'h0);
        chk({tag, "_out_c"},     {hif.out_c1x, hif.out_c1y, hif.out_c2x, hif.out_c2y}, 16'h0);
        chk({tag, "_err"},       16'(err), 16'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        hif.in_valid = 1'b0;
        hif.in_x     = '0;
        hif.in_y     = '0;
        #1 rst_n = 1'b0;
        #2 check_reset_values("por");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Ordered frame, constant valid, held result.
        send_frame(0, 0);
        @(negedge clk);
        hif.in_valid = 1'b0;
        chk("kick_in_ready", 16'(hif.in_ready), 16'h0);
        chk("kick_l_rst",    16'(l_rst), 16'h1);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("stream_l_rst", 16'(l_rst), 16'h0);
            chk("stream_x",     16'(l_x), 16'(i % 16));
            chk("stream_y",     16'(l_y), 16'(i / 16));
        end
        @(negedge clk);
        chk("wait_l_xy",  16'({l_y, l_x}), 16'h0);
        chk("wait_l_rst", 16'(l_rst), 16'h0);
        dir_c    = 16'h34AB;
        dir_done = 1'b1;
        @(negedge clk);
        dir_done = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("held_out_valid", 16'(hif.out_valid), 16'h1);
            chk("held_c1x", 16'(hif.out_c1x), 16'd3);
            chk("held_c1y", 16'(hif.out_c1y), 16'd4);
            chk("held_c2x", 16'(hif.out_c2x), 16'd10);
            chk("held_c2y", 16'(hif.out_c2y), 16'd11);
        end
        dir_rdy = 1'b1;
        @(negedge clk);
        dir_rdy = 1'b0;
        chk("post_hs_out_valid", 16'(hif.out_valid), 16'h0);
        chk("post_hs_in_ready",  16'(hif.in_ready), 16'h1);
        chk("post_hs_out_c",     {hif.out_c1x, hif.out_c1y, hif.out_c2x, hif.out_c2y}, 16'h34AB);

        // Toggling valid, random data, random core and host-out behaviour.
        core_rand = 1'b1;
        or_mode   = 1;
        fill_random();
        send_frame(1, 1);
        wait_load(1000);

        // Reset while streaming object 20.
        core_rand = 1'b0;
        dir_done  = 1'b0;
        or_mode   = 0;
        fill_random();
        send_frame(0, 1);
        wait_stream_idx(20);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Back-to-back frames with the result stream always ready.
        core_rand = 1'b1;
        or_mode   = 2;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            send_frame(2, 1);
            wait_load(1000);
        end

`ifdef LASER_FEEDER_TIMEOUT_EN
        core_rand = 1'b0;
        dir_done  = 1'b0;
        or_mode   = 0;
        fill_random();
        send_frame(2, 1);
        wait_load(200);
        chk("timeout_err",       16'(err), 16'h1);
        chk("timeout_out_valid", 16'(hif.out_valid), 16'h0);
        chk("timeout_in_ready",  16'(hif.in_ready), 16'h1);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/laser_feeder.md
LASER_FEEDER -- requirements
Module: laser_feeder

Interface
REQ-001 Parameter OBJ_NUM, default 40: number of objects per frame (6-bit counters).
REQ-002 Parameter TIMEOUT_CYC, default 4096: watchdog limit in cycles; used only when LASER_FEEDER_TIMEOUT_EN is defined.
REQ-003 CLK  in  1  single clock; every flop is rising-edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 IN_VALID in 1, IN_READY out 1, IN_X in 4, IN_Y in 4: host object stream, transfer when IN_VALID && IN_READY.
REQ-006 L_RST out 1, L_X out 4, L_Y out 4: drive the laser core's synchronous active-high reset and object inputs.
REQ-007 L_C1X, L_C1Y, L_C2X, L_C2Y in 4 each, L_DONE in 1: core results, valid only in the L_DONE cycle.
REQ-008 OUT_VALID out 1, OUT_READY in 1, OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y out 4 each: result stream to host.
REQ-009 ERR out 1: watchdog-expiry flag (tied 0 when the feature is compiled out).

Function
REQ-010 FSM states LOAD, KICK, STREAM, WAIT, RESULT; reset state LOAD.
REQ-011 LOAD: IN_READY=1; each transfer writes {IN_Y,IN_X} to obj_buf[wr_cnt] and increments wr_cnt; the OBJ_NUM-th transfer moves to KICK with wr_cnt cleared.
REQ-012 IN_READY SHALL be 0 in every state except LOAD; IN_VALID outside LOAD is ignored and nothing is stored.
REQ-013 KICK: L_RST=1 for exactly one cycle; next state STREAM with rd_cnt=0.
REQ-014 STREAM: L_RST=0, L_X/L_Y=obj_buf[rd_cnt] registered-free from rd_cnt; rd_cnt increments every cycle, no stalls; after rd_cnt=OBJ_NUM-1 go to WAIT.
REQ-015 The first rising edge with L_RST low SHALL present object 0; objects are delivered in host arrival order, one per cycle, 40 consecutive cycles.
REQ-016 Outside STREAM, L_X/L_Y SHALL be 0; L_RST SHALL be 1 in LOAD, KICK and RESULT, 0 in STREAM and WAIT.
REQ-017 WAIT: on L_DONE=1 capture L_C1X/L_C1Y/L_C2X/L_C2Y into output registers and go to RESULT; L_DONE in any other state is ignored.
REQ-018 RESULT: OUT_VALID=1 and OUT_C* stable until OUT_READY=1; on that edge OUT_VALID falls and FSM returns to LOAD; OUT_READY outside RESULT ignored.
REQ-019 OUT_READY already high on RESULT entry SHALL complete the transfer in one cycle; the next frame's first IN transfer is accepted the cycle after.
REQ-020 OUT_C* SHALL hold the last captured values after transfer until the next capture.
REQ-021 Counter wrap: wr_cnt and rd_cnt never exceed OBJ_NUM-1.

Reset
REQ-022 RST_N low SHALL immediately force: state LOAD, wr_cnt=rd_cnt=0, IN_READY=0 while low, L_RST=1, L_X=L_Y=0, OUT_VALID=0, OUT_C*=0, ERR=0.
REQ-023 obj_buf need not be reset; a partial frame in progress at reset is discarded.
REQ-024 Reset assertion mid-STREAM or mid-WAIT SHALL leave L_RST=1 so the core is also held reset.

Configuration
REQ-025 Macro LASER_FEEDER_TIMEOUT_EN defined: watchdog counts cycles in WAIT; reaching TIMEOUT_CYC without L_DONE sets ERR=1 (sticky until RST_N), returns to LOAD without OUT_VALID.
REQ-026 Macro undefined: no watchdog logic, WAIT waits indefinitely, ERR tied 0.

Structure
REQ-027 Shared package laser_pkg: OBJ_NUM default, state encoding, packed coordinate type {y[3:0],x[3:0]}, result type {c1,c2}.
REQ-028 One sub-module natural: laser_obj_buf (OBJ_NUM x 8 register file, one write port, one async read port).

Verification
REQ-029 40 objects (x=i%16, y=i/16) with IN_VALID constant -> IN_READY drops after 40th transfer, L_RST high 1 cycle, then L_X/L_Y match i in order over 40 cycles.
REQ-030 IN_VALID toggling every other cycle -> exactly 40 transfers stored, stream order unchanged, no duplicates.
REQ-031 Core model pulses L_DONE with C1=(3,4), C2=(10,11), OUT_READY low 5 cycles -> OUT_VALID high and OUT_C*=3,4,10,11 stable for 5 cycles, low after handshake.
REQ-032 RST_N low at rd_cnt=20 -> outputs at reset values within same cycle, L_RST=1; next frame restarts at object 0.
REQ-033 TIMEOUT_EN, TIMEOUT_CYC=16, no L_DONE -> ERR=1 at 16th WAIT cycle, OUT_VALID stays 0, IN_READY=1 next cycle.
REQ-034 Back-to-back frames with OUT_READY tied 1 -> second frame's results correct, no lost or extra L_RST pulse.
